cpu_bus_target: RTL

- Responder side of the CPU bus: decodes each cycle issued by the CPU's phi/a/rd/wr/dout interface and returns read data on din.
- Owns the on-chip high RAM, HRAM (FF80-FFFE, 127 B), the interrupt enable register IE (FFFF) and the interrupt flag register IF (FF0F).
- Any other address is forwarded to external logic over a one-clock strobe interface.
- Produces the pending-interrupt vector for the interrupt dispatch logic.

---
 rtl/cpu_bus_target_pkg.sv | 36 +++
 rtl/cpu_bus_target_if.sv | 15 +
 rtl/cpu_bus_target_hram.sv | 32 +++
 rtl/cpu_bus_target.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_target_pkg.sv
// cpu_bus_pkg: shared constants and types for the CPU bus responder.
// Holds the decoded address map, the access FSM state encoding, the
// read-source select used between the decode clock and the data clock,
// and the bit positions of the five interrupt sources in IE/IF.
package cpu_bus_pkg;

  localparam logic [15:0] HRAM_BASE  = 16'hFF80;
  localparam logic [15:0] IF_ADDR    = 16'hFF0F;
  localparam logic [15:0] IE_ADDR    = 16'hFFFF;
  localparam logic [15:0] BOOT_ADDR  = 16'hFF50;
  localparam logic [7:0]  OPEN_BUS   = 8'hFF;
  localparam int          HRAM_DEPTH = 127;

  // Interrupt bit positions within IE[4:0] / IF[4:0]
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_DATA = 2'd1,
    WR_DONE = 2'd2
  } state_e;

  // Which source drives din on the clock after a read is decoded
  typedef enum logic [2:0] {
    SRC_EXT  = 3'd0,
    SRC_HRAM = 3'd1,
    SRC_IF   = 3'd2,
    SRC_IE   = 3'd3,
    SRC_BOOT = 3'd4
  } src_e;

endpackage

// File: rtl/cpu_bus_target_if.sv
// cpu_bus_target_if: CPU-side bus between the CPU core and the responder.
//   a    : 16-bit address          dout : CPU write data
//   rd   : read strobe             wr   : write strobe
//   din  : read data back to the CPU
// master modport is the CPU, slave modport is cpu_bus_target.
interface cpu_bus_target_if;
  logic [15:0] a;
  logic [7:0]  dout;
  logic        rd;
  logic        wr;
  logic [7:0]  din;

  modport master (output a, output dout, output rd, output wr, input din);
  modport slave  (input a, input dout, input rd, input wr, output din);
endinterface

// File: rtl/cpu_bus_target_hram.sv
// cpu_bus_hram: 127x8 single-port synchronous RAM, one-clock read latency.
//   clk   : clock              we    : write enable
//   re    : read enable        addr  : word address 0..126
//   wdata : write data         rdata : read data, valid the clock after re
// Contents are intentionally not reset.
module cpu_bus_hram
  import cpu_bus_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic       re,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [HRAM_DEPTH];
  logic [7:0] rdata_q;

  // Storage array write and registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cpu_bus_target.sv
// cpu_bus_target: responder for the CPU bus.
// Decodes each rd/wr strobe edge, serves HRAM (FF80-FFFE), IF (FF0F) and
// IE (FFFF) locally and forwards every other address to external logic
// through one-clock ext_rd / ext_wr strobes. Read data appears on din two
// clocks after rd rises and holds until the next read.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   bus (slave)          : a, dout, rd, wr in; din out
//   ext_rd/ext_wr        : one-clock strobes for external addresses
//   ext_a/ext_wdata      : registered external address / write data
//   ext_rdata/ext_hit    : external read data and claim
//   irq_req/irq_ack      : interrupt set pulses / one-hot clears
//   irq_pending          : registered IE[4:0] & IF[4:0]
//   boot_off             : sticky boot-ROM disable (BOOT_LOCK_EN builds only)
// Build option: define BOOT_LOCK_EN to map the boot lock register at FF50.
module cpu_bus_target
  import cpu_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  cpu_bus_target_if.slave bus,
  output logic        ext_rd,
  output logic        ext_wr,
  output logic [15:0] ext_a,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_hit,
  input  logic [4:0]  irq_req,
  input  logic [4:0]  irq_ack,
  output logic [4:0]  irq_pending
`ifdef BOOT_LOCK_EN
  ,
  output logic        boot_off
`endif
);

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic        rd_q, wr_q;
  logic [7:0]  din_q, din_d;
  logic [7:0]  ie_q, ie_d;
  logic [4:0]  if_q, if_d;
  logic [4:0]  pend_q, pend_d;
  logic        ext_rd_q, ext_rd_d, ext_wr_q, ext_wr_d;
  logic [15:0] ext_a_q, ext_a_d;
  logic [7:0]  ext_wdata_q, ext_wdata_d;
  logic        boot_off_q, boot_off_d;

  logic        rd_go_s, wr_go_s;
  logic        is_hram_s, is_if_s, is_ie_s, is_boot_s, is_ext_s;
  logic [6:0]  hram_addr_s;
  logic [7:0]  hram_rdata_s;

  // Address decode and strobe edge detection; a write rise masks a read rise
  always_comb begin
    wr_go_s     = bus.wr & ~wr_q;
    rd_go_s     = bus.rd & ~rd_q & ~wr_go_s;
    is_hram_s   = (bus.a >= HRAM_BASE) && (bus.a <= (HRAM_BASE + 16'd126));
    is_if_s     = (bus.a == IF_ADDR);
    is_ie_s     = (bus.a == IE_ADDR);
`ifdef BOOT_LOCK_EN
    is_boot_s   = (bus.a == BOOT_ADDR);
`else
    is_boot_s   = 1'b0;
`endif
    is_ext_s    = ~(is_hram_s | is_if_s | is_ie_s | is_boot_s);
    // HRAM_BASE is 128-aligned, so only the low seven bits matter
    hram_addr_s = bus.a[6:0] - HRAM_BASE[6:0];
  end

  cpu_bus_hram u_hram (
    .clk   (clk),
    .we    (wr_go_s & is_hram_s),
    .re    (rd_go_s & is_hram_s),
    .addr  (hram_addr_s),
    .wdata (bus.dout),
    .rdata (hram_rdata_s)
  );

  // FSM next state, register updates and read data selection
  always_comb begin
    state_d     = IDLE;
    src_d       = src_q;
    din_d       = din_q;
    ie_d        = ie_q;
    if_d        = if_q;
    ext_rd_d    = 1'b0;
    ext_wr_d    = 1'b0;
    ext_a_d     = ext_a_q;
    ext_wdata_d = ext_wdata_q;
    boot_off_d  = boot_off_q;

    if (wr_go_s) begin
      state_d = WR_DONE;
    end else if (rd_go_s) begin
      state_d = RD_DATA;
    end else begin
      state_d = IDLE;
    end

    if (rd_go_s) begin
      if (is_hram_s)      src_d = SRC_HRAM;
      else if (is_if_s)   src_d = SRC_IF;
      else if (is_ie_s)   src_d = SRC_IE;
      else if (is_boot_s) src_d = SRC_BOOT;
      else                src_d = SRC_EXT;
    end else begin
      src_d = src_q;
    end

    if (wr_go_s && is_ie_s) begin
      ie_d = bus.dout;
    end else begin
      ie_d = ie_q;
    end

    if (wr_go_s && is_boot_s && (bus.dout != 8'h00)) begin
      boot_off_d = 1'b1;
    end else begin
      boot_off_d = boot_off_q;
    end

    // IF priority, lowest first: hold, CPU write, ack clear, request set
    if (wr_go_s && is_if_s) begin
      if_d = bus.dout[4:0];
    end else begin
      if_d = if_q;
    end
    if_d = (if_d & ~irq_ack) | irq_req;

    if (is_ext_s && (wr_go_s || rd_go_s)) begin
      ext_a_d  = bus.a;
      ext_rd_d = rd_go_s;
      ext_wr_d = wr_go_s;
    end else begin
      ext_a_d  = ext_a_q;
    end
    if (is_ext_s && wr_go_s) begin
      ext_wdata_d = bus.dout;
    end else begin
      ext_wdata_d = ext_wdata_q;
    end

    case (state_q)
      RD_DATA: begin
        case (src_q)
          SRC_HRAM: din_d = hram_rdata_s;
          SRC_IF:   din_d = {3'b111, if_q};
          SRC_IE:   din_d = ie_q;
          SRC_BOOT: din_d = {7'h7F, boot_off_q};
          SRC_EXT:  din_d = ext_hit ? ext_rdata : OPEN_BUS;
          default:  din_d = OPEN_BUS;
        endcase
      end
      IDLE:    din_d = din_q;
      WR_DONE: din_d = din_q;
      default: din_d = din_q;
    endcase

    pend_d = ie_d[4:0] & if_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= SRC_EXT;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      din_q       <= OPEN_BUS;
      ie_q        <= 8'h00;
      if_q        <= 5'h00;
      pend_q      <= 5'h00;
      ext_rd_q    <= 1'b0;
      ext_wr_q    <= 1'b0;
      ext_a_q     <= 16'h0000;
      ext_wdata_q <= 8'h00;
      boot_off_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      rd_q        <= bus.rd;
      wr_q        <= bus.wr;
      din_q       <= din_d;
      ie_q        <= ie_d;
      if_q        <= if_d;
      pend_q      <= pend_d;
      ext_rd_q    <= ext_rd_d;
      ext_wr_q    <= ext_wr_d;
      ext_a_q     <= ext_a_d;
      ext_wdata_q <= ext_wdata_d;
      boot_off_q  <= boot_off_d;
    end
  end

  assign bus.din     = din_q;
  assign ext_rd      = ext_rd_q;
  assign ext_wr      = ext_wr_q;
  assign ext_a       = ext_a_q;
  assign ext_wdata   = ext_wdata_q;
  assign irq_pending = pend_q;
`ifdef BOOT_LOCK_EN
  assign boot_off    = boot_off_q;
`endif

endmodule
